// File: rtl/usb4_symbol_packer_if.sv
// Byte-side and symbol-side signal bundle for usb4_symbol_packer.
// Handshake: a byte moves on an enc_clk rise with lane_valid && byte_ready. A symbol is consumed
// on an enc_clk rise with enc_valid && enc_ready, and lane_tx_enc/enc_valid hold while enc_valid && !enc_ready.
interface usb4_symbol_packer_if #(
  parameter int NUM_LANES = 2,
  parameter int SYM_W     = 132
);
  logic [3:0]                 d_sel;
  logic [NUM_LANES*8-1:0]     lane_tx;
  logic                       lane_valid;
  logic                       byte_ready;
  logic [NUM_LANES*SYM_W-1:0] lane_tx_enc;
  logic                       enc_valid;
  logic                       enc_ready;
  logic                       new_sym;
  logic                       drop_err;

  modport slave (
    input  d_sel, lane_tx, lane_valid, enc_ready,
    output byte_ready, lane_tx_enc, enc_valid, new_sym, drop_err
  );

  modport master (
    output d_sel, lane_tx, lane_valid, enc_ready,
    input  byte_ready, lane_tx_enc, enc_valid, new_sym, drop_err
  );
endinterface

// File: rtl/usb4_symbol_packer.sv
// Packs NUM_LANES byte streams into Gen3 128b/132b or Gen2 64b/66b symbols, or passes bytes
// through in Gen4 mode, with a one-block pending buffer behind the output slot.
module usb4_symbol_packer #(
  parameter int NUM_LANES = 2,
  parameter int SYM_W     = 132
) (
  input  logic                       enc_clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 gen_speed,
  usb4_symbol_packer_if.slave        bus,
  output logic [1:0]                 state_dbg
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_PEND = 2'd2} state_t;

  state_t                      state, state_n;
  logic                        active, slot_take, accept, drop, last, slot_free;
  logic [3:0]                  byte_cnt, last_idx, dsel_q, dsel_eff;
  logic [1:0]                  gen_q;
  logic                        pend_valid;
  logic [NUM_LANES*128-1:0]    acc, acc_next;
  logic [NUM_LANES*SYM_W-1:0]  sym, pend_data;

  always_comb begin
    active         = enable && (gen_speed != 2'd3);
    slot_take      = bus.enc_valid && bus.enc_ready;
    // rst gating keeps byte_ready low while reset is asserted
    bus.byte_ready = rst && active && !(pend_valid && !slot_take);
    accept         = bus.lane_valid && bus.byte_ready;
    drop           = (gen_speed != gen_q) && ((byte_cnt != 4'd0) || pend_valid);
    case (gen_speed)
      2'd1:    last_idx = 4'd15;
      2'd2:    last_idx = 4'd7;
      default: last_idx = 4'd0;
    endcase
    last      = (byte_cnt == last_idx);
    // pending block always goes out ahead of a block completing in the same cycle
    slot_free = (!bus.enc_valid || bus.enc_ready) && !pend_valid;
    dsel_eff  = (byte_cnt == 4'd0) ? bus.d_sel : dsel_q;
  end

  always_comb begin
    acc_next = acc;
    for (int l = 0; l < NUM_LANES; l++)
      acc_next[l*128 + int'(byte_cnt)*8 +: 8] = bus.lane_tx[l*8 +: 8];
  end

  always_comb begin
    sym = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      case (gen_speed)
        2'd1: begin
          sym[l*SYM_W +: 128]     = acc_next[l*128 +: 128];
          sym[l*SYM_W + 128 +: 4] = (dsel_eff == 4'd8) ? 4'b0101 : 4'b1010;
        end
        2'd2: begin
          sym[l*SYM_W +: 64]     = acc_next[l*128 +: 64];
          sym[l*SYM_W + 64 +: 2] = (dsel_eff == 4'd8) ? 2'b01 : 2'b10;
        end
        2'd0:    sym[l*SYM_W +: 8] = acc_next[l*128 +: 8];
        default: ;
      endcase
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!active || drop)                state_n = S_IDLE;
    else if (accept && !last)           state_n = S_FILL;
    else if (accept && last)            state_n = slot_free ? S_IDLE : S_PEND;
    else if (pend_valid && slot_take)   state_n = S_IDLE;
  end

  assign state_dbg = state;

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      byte_cnt        <= '0;
      dsel_q          <= '0;
      gen_q           <= '0;
      pend_valid      <= 1'b0;
      pend_data       <= '0;
      acc             <= '0;
      bus.lane_tx_enc <= '0;
      bus.enc_valid   <= 1'b0;
      bus.new_sym     <= 1'b0;
      bus.drop_err    <= 1'b0;
    end else begin
      gen_q        <= gen_speed;
      bus.new_sym  <= 1'b0;
      bus.drop_err <= 1'b0;
      if (!active) begin
        byte_cnt        <= '0;
        pend_valid      <= 1'b0;
        acc             <= '0;
        bus.enc_valid   <= 1'b0;
        bus.lane_tx_enc <= '0;
        bus.drop_err    <= (byte_cnt != 4'd0) || pend_valid;
      end else if (drop) begin
        // partial and pending blocks are lost; the output slot drains as usual
        byte_cnt     <= '0;
        pend_valid   <= 1'b0;
        bus.drop_err <= 1'b1;
        if (slot_take) bus.enc_valid <= 1'b0;
      end else begin
        if (slot_take) bus.enc_valid <= 1'b0;
        if (pend_valid && slot_take) begin
          bus.lane_tx_enc <= pend_data;
          bus.enc_valid   <= 1'b1;
          bus.new_sym     <= 1'b1;
          pend_valid      <= 1'b0;
        end
        if (accept) begin
          acc <= acc_next;
          if (byte_cnt == 4'd0) dsel_q <= bus.d_sel;
          if (last) begin
            byte_cnt <= '0;
            if (slot_free) begin
              bus.lane_tx_enc <= sym;
              bus.enc_valid   <= 1'b1;
              bus.new_sym     <= 1'b1;
            end else begin
              pend_data  <= sym;
              pend_valid <= 1'b1;
            end
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_usb4_symbol_packer.sv
// Self-checking bench for usb4_symbol_packer: directed scenarios plus randomized blocks
// compared against a block-level symbol model.
module tb_usb4_symbol_packer;
  localparam int NL = 2;
  localparam int SW = 132;
  localparam int CW = NL*SW;

  logic       enc_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] gen_speed = 2'd1;
  logic [1:0] state_dbg;

  usb4_symbol_packer_if #(.NUM_LANES(NL), .SYM_W(SW)) bus();

  usb4_symbol_packer #(.NUM_LANES(NL), .SYM_W(SW)) dut (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .enable    (enable),
    .gen_speed (gen_speed),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 enc_clk = ~enc_clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            sym_cnt = 0;
  int            drop_cnt = 0;
  int            cyc = 0;
  logic [CW-1:0] exp_q[$];
  logic [7:0]    blk [NL][16];
  bit            rand_ready = 0;
  bit            stab_on = 0;
  bit            hold_prev = 0;
  logic [CW-1:0] data_prev;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: symbol built from the block's bytes and header rules
  function automatic logic [CW-1:0] model_sym(input int gen, input logic [3:0] ds);
    logic [CW-1:0] s;
    logic [SW-1:0] ls;
    s = '0;
    for (int l = 0; l < NL; l++) begin
      ls = '0;
      if (gen == 1) begin
        for (int k = 0; k < 16; k++) ls = ls | (SW'(blk[l][k]) << (8*k));
        ls = ls | (SW'((ds == 4'd8) ? 4'b0101 : 4'b1010) << 128);
      end else if (gen == 2) begin
        for (int k = 0; k < 8; k++) ls = ls | (SW'(blk[l][k]) << (8*k));
        ls = ls | (SW'((ds == 4'd8) ? 2'b01 : 2'b10) << 64);
      end else begin
        ls = SW'(blk[l][0]);
      end
      s = s | (CW'(ls) << (SW*l));
    end
    return s;
  endfunction

  always @(posedge enc_clk) cyc <= cyc + 1;

  always @(posedge enc_clk) if (rand_ready) begin
    #1;
    bus.enc_ready = ($urandom_range(0, 3) != 0);
  end

  // scoreboard: every loaded symbol must match the oldest expected one
  always @(negedge enc_clk) begin
    if (bus.drop_err) drop_cnt++;
    if (rst && bus.new_sym) begin
      sym_cnt++;
      check("sym_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sym_data", bus.lane_tx_enc, exp_q.pop_front());
    end
  end

  always @(negedge enc_clk) begin
    if (stab_on && hold_prev) begin
      check("hold_data", bus.lane_tx_enc, data_prev);
      check("hold_valid", bus.enc_valid, 1);
    end
    hold_prev = stab_on && rst && bus.enc_valid && !bus.enc_ready;
    data_prev = bus.lane_tx_enc;
  end

  // driver: offers n_send bytes of a block; pushes the expected symbol if the block completes
  task automatic send_block(input int gen, input logic [3:0] ds, input int pat, input int n_send, input bit gaps);
    int n;
    int guard;
    bit ok;
    n = (gen == 1) ? 16 : ((gen == 2) ? 8 : 1);
    for (int k = 0; k < n_send; k++) begin
      for (int l = 0; l < NL; l++) begin
        case (pat)
          1:       blk[l][k] = (l == 0) ? 8'(k) : 8'(8'hF0 + k);
          2:       blk[l][k] = 8'hA5;
          default: blk[l][k] = 8'($urandom_range(0, 255));
        endcase
        bus.lane_tx[l*8 +: 8] = blk[l][k];
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.lane_valid = 1'b0;
        @(posedge enc_clk); #1;
      end
      bus.d_sel      = (k == 0) ? ds : 4'($urandom_range(0, 15));
      bus.lane_valid = 1'b1;
      guard = 0;
      ok    = 0;
      while (!ok && guard < 1000) begin
        @(negedge enc_clk);
        ok = bus.byte_ready;
        @(posedge enc_clk); #1;
        guard++;
      end
      if (!ok) begin
        check("accept_timeout", ok, 1);
        bus.lane_valid = 1'b0;
        return;
      end
    end
    bus.lane_valid = 1'b0;
    if (n_send == n) exp_q.push_back(model_sym(gen, ds));
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge enc_clk); #1;
      g++;
    end
    check("drain", exp_q.size() == 0, 1);
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int c0, d0, t0, nb;
    int g;
    logic [CW-1:0] e;
    bus.lane_tx = '0; bus.lane_valid = 1'b0; bus.d_sel = '0; bus.enc_ready = 1'b0;
    enable = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge enc_clk);
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_enc_valid", bus.enc_valid, 0);
    check("rst_enc_data", bus.lane_tx_enc, 0);
    check("rst_new_sym", bus.new_sym, 0);
    check("rst_drop_err", bus.drop_err, 0);
    check("rst_state", state_dbg, 0);
    @(posedge enc_clk); #1 rst = 1'b1;
    @(negedge enc_clk);
    check("idle_byte_ready", bus.byte_ready, 1);
    @(posedge enc_clk); #1;
    stab_on = 1;

    // Gen3 ordered set, spec byte pattern
    bus.enc_ready = 1'b1;
    c0 = sym_cnt;
    send_block(1, 4'd3, 1, 16, 0);
    @(negedge enc_clk);
    check("g3_new_sym", bus.new_sym, 1);
    check("g3_enc_valid", bus.enc_valid, 1);
    check("g3_hdr_lane0", bus.lane_tx_enc[131:128], 4'b1010);
    @(negedge enc_clk);
    check("g3_pulse_once", bus.new_sym, 0);
    check("g3_count", sym_cnt - c0, 1);
    @(posedge enc_clk); #1;

    // Gen2 transport data, 24 bytes back-to-back
    gen_speed = 2'd2;
    c0 = sym_cnt; d0 = drop_cnt; t0 = cyc;
    repeat (3) send_block(2, 4'd8, 0, 8, 0);
    check("g2_no_bubble", cyc - t0, 24);
    wait_drain();
    check("g2_count", sym_cnt - c0, 3);
    check("g2_no_drop", drop_cnt - d0, 0);

    // backpressure: second Gen3 block waits in the pending buffer
    gen_speed = 2'd1;
    bus.enc_ready = 1'b0;
    send_block(1, 4'd8, 0, 16, 0);
    send_block(1, 4'd3, 0, 16, 0);
    @(negedge enc_clk);
    check("bp_byte_ready_low", bus.byte_ready, 0);
    check("bp_state_pend", state_dbg, 2);
    check("bp_enc_valid", bus.enc_valid, 1);
    @(posedge enc_clk); #1 bus.enc_ready = 1'b1;
    @(negedge enc_clk);
    check("bp_byte_ready_back", bus.byte_ready, 1);
    @(posedge enc_clk); #1 bus.enc_ready = 1'b0;
    @(negedge enc_clk);
    check("bp_pend_load", bus.new_sym, 1);
    check("bp_state_idle", state_dbg, 0);
    check("bp_ready_after", bus.byte_ready, 1);
    @(posedge enc_clk); #1 bus.enc_ready = 1'b1;
    wait_drain();

    // Gen4 bypass
    gen_speed = 2'd0;
    c0 = sym_cnt;
    send_block(0, 4'd8, 2, 1, 0);
    @(negedge enc_clk);
    check("g4_new_sym", bus.new_sym, 1);
    e = '0; e[7:0] = 8'hA5; e[SW +: 8] = 8'hA5;
    check("g4_bypass", bus.lane_tx_enc, e);
    @(posedge enc_clk); #1;
    t0 = cyc;
    repeat (8) send_block(0, 4'($urandom_range(0, 15)), 0, 1, 0);
    check("g4_throughput", cyc - t0, 8);
    wait_drain();
    check("g4_count", sym_cnt - c0, 9);

    // mode change mid-block drops the partial Gen3 block
    gen_speed = 2'd1;
    @(posedge enc_clk); #1;
    c0 = sym_cnt; d0 = drop_cnt;
    send_block(1, 4'd8, 0, 5, 0);
    gen_speed = 2'd2;
    @(posedge enc_clk);
    @(negedge enc_clk);
    check("mc_drop_err", bus.drop_err, 1);
    check("mc_no_sym", bus.new_sym, 0);
    check("mc_state", state_dbg, 0);
    @(negedge enc_clk);
    check("mc_drop_pulse", bus.drop_err, 0);
    @(posedge enc_clk); #1;
    send_block(2, 4'd8, 0, 8, 0);
    wait_drain();
    check("mc_sym_count", sym_cnt - c0, 1);
    check("mc_drop_count", drop_cnt - d0, 1);

    // randomized blocks with random backpressure, d_sel and input gaps
    rand_ready = 1;
    for (int it = 0; it < 12; it++) begin
      g = $urandom_range(0, 2);
      gen_speed = 2'(g);
      nb = $urandom_range(1, 4);
      d0 = drop_cnt;
      for (int b = 0; b < nb; b++)
        send_block(g, ($urandom_range(0, 1) != 0) ? 4'd8 : 4'($urandom_range(0, 15)), 0,
                   (g == 1) ? 16 : ((g == 2) ? 8 : 1), 1);
      wait_drain();
      check("rnd_no_drop", drop_cnt - d0, 0);
    end
    rand_ready = 0;
    @(posedge enc_clk); #2 bus.enc_ready = 1'b1;
    gen_speed = 2'd1;
    @(posedge enc_clk); #1;
    @(posedge enc_clk); #1;

    // enable low mid-block flushes everything
    bus.enc_ready = 1'b0;
    send_block(1, 4'd8, 0, 16, 0);
    send_block(1, 4'd8, 0, 5, 0);
    stab_on = 0;
    enable = 1'b0;
    @(posedge enc_clk);
    @(negedge enc_clk);
    check("en_enc_valid", bus.enc_valid, 0);
    check("en_enc_data", bus.lane_tx_enc, 0);
    check("en_new_sym", bus.new_sym, 0);
    check("en_drop_err", bus.drop_err, 1);
    check("en_byte_ready", bus.byte_ready, 0);
    @(posedge enc_clk); #1 enable = 1'b1;
    @(negedge enc_clk);
    check("en_recover_ready", bus.byte_ready, 1);
    @(posedge enc_clk); #1;

    // asynchronous reset while a block is pending
    send_block(1, 4'd3, 0, 16, 0);
    send_block(1, 4'd8, 0, 16, 0);
    @(negedge enc_clk);
    check("rp_pending", bus.byte_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("rp_enc_valid", bus.enc_valid, 0);
    check("rp_enc_data", bus.lane_tx_enc, 0);
    check("rp_byte_ready", bus.byte_ready, 0);
    check("rp_state", state_dbg, 0);
    exp_q.delete();
    @(negedge enc_clk);
    check("rp_hold_ready", bus.byte_ready, 0);
    @(posedge enc_clk); #1 rst = 1'b1;
    bus.enc_ready = 1'b1;
    stab_on = 1;
    c0 = sym_cnt;
    send_block(1, 4'd8, 0, 16, 0);
    wait_drain();
    check("rp_after_count", sym_cnt - c0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
